mux64_32: RTL and testbench



---
 rtl/mux64_32.sv | 42 ++++
 tb/tb_mux64_32.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux64_32.sv
// rtl/mux64_32.sv - 2:1 word mux with combinational output and registered copy of output and select
module mux64_32 #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             s_q
);

    logic [WIDTH-1:0] c_d;
    logic             s_d;

    always_comb begin
        c = s ? b : a;
    end

    // Reset wins over enable; without enable both registers hold.
    always_comb begin
        c_d = c_q;
        s_d = s_q;
        if (rst) begin
            c_d = RESET_VAL;
            s_d = 1'b0;
        end else if (en) begin
            c_d = c;
            s_d = s;
        end
    end

    always_ff @(posedge clk) begin
        c_q <= c_d;
        s_q <= s_d;
    end

endmodule

// File: tb/tb_mux64_32.sv
// tb/tb_mux64_32.sv - self-checking bench for mux64_32
module tb_mux64_32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        en;
    logic [31:0] c;
    logic [31:0] c_q;
    logic        s_q;

    int n_pass  = 0;
    int n_total = 0;

    mux64_32 #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .s   (s),
        .en  (en),
        .c   (c),
        .c_q (c_q),
        .s_q (s_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        en;
        logic [31:0] exp_c;
        logic [31:0] exp_cq;
        logic        exp_sq;
    } vec_t;

    vec_t vecs[5];

    // Reference registered state, advanced by the rules of the block at each edge.
    logic [31:0] m_cq;
    logic        m_sq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick(input logic [31:0] x, input logic [31:0] y, input logic sel);
        logic [31:0] words[2];
        words[0] = x;
        words[1] = y;
        return words[int'(sel)];
    endfunction

    initial begin
        vecs[0] = '{32'h0,        32'd40,       1'b1, 1'b1, 32'd40,       32'd40,       1'b1};
        vecs[1] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{32'h11111111, 32'h22222222, 1'b1, 1'b0, 32'h22222222, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{32'h11111111, 32'h22222222, 1'b1, 1'b1, 32'h22222222, 32'h22222222, 1'b1};
        vecs[4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h22222222, 1'b1};

        rst = 1'b1; en = 1'b0; a = 32'h0; b = 32'h0; s = 1'b0;
        @(negedge clk);
        tick();
        check("reset_cq", c_q, 32'h0);
        check("reset_sq", {31'b0, s_q}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            a = vecs[i].a; b = vecs[i].b; s = vecs[i].s; en = vecs[i].en;
            #1;
            check($sformatf("vec%0d_c", i), c, vecs[i].exp_c);
            tick();
            check($sformatf("vec%0d_cq", i), c_q, vecs[i].exp_cq);
            check($sformatf("vec%0d_sq", i), {31'b0, s_q}, {31'b0, vecs[i].exp_sq});
        end

        // s toggles with inputs fixed: c must follow without any clock dependence.
        a = 32'hFFFFFFFF; b = 32'h0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = i[0];
            #1;
            check($sformatf("toggle%0d_c", i), c, i[0] ? 32'h0 : 32'hFFFFFFFF);
            #9;
        end

        // Reset priority over enable.
        a = 32'h0; b = 32'd40; s = 1'b1; en = 1'b1;
        tick();
        check("rp_load_cq", c_q, 32'd40);
        rst = 1'b1; b = 32'd99;
        #1;
        check("rp_c_before", c, 32'd99);
        tick();
        check("rp_cq", c_q, 32'h0);
        check("rp_sq", {31'b0, s_q}, 32'h0);
        check("rp_c_after", c, 32'd99);
        rst = 1'b0;
        tick();
        check("rp_release_cq", c_q, 32'd99);
        check("rp_release_sq", {31'b0, s_q}, 32'h1);

        // Hold with enable low.
        b = 32'd40; s = 1'b1; en = 1'b1;
        tick();
        en = 1'b0; b = 32'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_cq", i), c_q, 32'd40);
            check($sformatf("hold%0d_c", i), c, 32'd7);
        end
        en = 1'b1;
        tick();
        check("hold_release_cq", c_q, 32'd7);

        // Walking-one on both inputs, distinct bit positions so a wrong pick is visible.
        en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            for (int sv = 0; sv < 2; sv++) begin
                a = 32'h1 << i;
                b = 32'h1 << (31 - i);
                s = sv[0];
                #1;
                check($sformatf("walk%0d_s%0d", i, sv), c, sv[0] ? (32'h1 << (31 - i)) : (32'h1 << i));
            end
        end

        // Randomized traffic against the reference model, including occasional reset.
        rst = 1'b1;
        tick();
        m_cq = 32'h0;
        m_sq = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            a   = $urandom;
            b   = $urandom;
            s   = $urandom_range(0, 1) == 1;
            en  = $urandom_range(0, 2) != 0;
            rst = $urandom_range(0, 15) == 0;
            #1;
            check($sformatf("rnd%0d_c", i), c, pick(a, b, s));
            if (rst) begin
                m_cq = 32'h0;
                m_sq = 1'b0;
            end else if (en) begin
                m_cq = pick(a, b, s);
                m_sq = s;
            end
            tick();
            check($sformatf("rnd%0d_cq", i), c_q, m_cq);
            check($sformatf("rnd%0d_sq", i), {31'b0, s_q}, {31'b0, m_sq});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
